branch_resolve_ctrl: RTL

Sequences the shared branch comparator for the rv32 core. It accepts one branch or jump per handshake from decode and latches the operands. It drives the comparator's unsigned-select and operands, evaluates the taken condition from the comparator's eq/lt results, and computes target and link values. On a taken branch it issues a fetch redirect and holds a pipeline flush window. Fetch statically predicts not-taken, so only taken control transfers redirect.

---
 rtl/branch_resolve_ctrl_if.sv | 59 +++++
 rtl/branch_resolve_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Bundles the decode, comparator, result, fetch-redirect, flush and statistics
// signals of the branch resolve controller.
// slave = the controller itself; master = the surrounding pipeline.
interface branch_resolve_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
);
    // Decode handshake
    logic             IDU_i_valid;
    logic             IDU_o_ready;
    logic             IDU_i_is_branch;
    logic             IDU_i_is_jal;
    logic             IDU_i_is_jalr;
    logic [2:0]       IDU_i_funct3;
    logic [WIDTH-1:0] IDU_i_pc;
    logic [WIDTH-1:0] IDU_i_imm;
    logic [WIDTH-1:0] IDU_i_valA;
    logic [WIDTH-1:0] IDU_i_valB;
    // Shared comparator
    logic             CTRL_o_br_un;
    logic [WIDTH-1:0] CTRL_o_valA;
    logic [WIDTH-1:0] CTRL_o_valB;
    logic             BR_JMP_i_br_eq;
    logic             BR_JMP_i_br_lt;
    // Resolution result
    logic             RES_o_valid;
    logic             RES_o_taken;
    logic [WIDTH-1:0] RES_o_link;
    logic             RES_o_illegal;
    logic             RES_o_misalign;
    // Fetch redirect and pipeline flush
    logic             IFU_o_redirect_valid;
    logic [WIDTH-1:0] IFU_o_redirect_pc;
    logic             IFU_i_redirect_ready;
    logic             PIPE_o_flush;
    // Statistics
    logic [CNT_W-1:0] STAT_o_branches;
    logic [CNT_W-1:0] STAT_o_taken;

    modport slave (
        input  IDU_i_valid, IDU_i_is_branch, IDU_i_is_jal, IDU_i_is_jalr, IDU_i_funct3,
               IDU_i_pc, IDU_i_imm, IDU_i_valA, IDU_i_valB,
               BR_JMP_i_br_eq, BR_JMP_i_br_lt, IFU_i_redirect_ready,
        output IDU_o_ready, CTRL_o_br_un, CTRL_o_valA, CTRL_o_valB,
               RES_o_valid, RES_o_taken, RES_o_link, RES_o_illegal, RES_o_misalign,
               IFU_o_redirect_valid, IFU_o_redirect_pc, PIPE_o_flush,
               STAT_o_branches, STAT_o_taken
    );

    modport master (
        output IDU_i_valid, IDU_i_is_branch, IDU_i_is_jal, IDU_i_is_jalr, IDU_i_funct3,
               IDU_i_pc, IDU_i_imm, IDU_i_valA, IDU_i_valB,
               BR_JMP_i_br_eq, BR_JMP_i_br_lt, IFU_i_redirect_ready,
        input  IDU_o_ready, CTRL_o_br_un, CTRL_o_valA, CTRL_o_valB,
               RES_o_valid, RES_o_taken, RES_o_link, RES_o_illegal, RES_o_misalign,
               IFU_o_redirect_valid, IFU_o_redirect_pc, PIPE_o_flush,
               STAT_o_branches, STAT_o_taken
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution sequencer: latches one control-transfer op from decode,
// evaluates it on the shared comparator, and on a taken, aligned transfer
// redirects fetch and holds a flush window. Fetch predicts not-taken.
module branch_resolve_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  bus
);
    localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FcW-1:0] FcLast = FcW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StEval, StRedirect, StFlush} state_e;
    // KindNone: valid with no kind flag; resolved as an illegal not-taken branch
    typedef enum logic [1:0] {KindBranch, KindJal, KindJalr, KindNone} kind_e;

    state_e           state_q, state_d;
    logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;

    logic [WIDTH-1:0] pc_q, imm_q, val_a_q, val_b_q;
    logic [2:0]       funct3_q;
    kind_e            kind_q, kind_in;

    logic             res_valid_q, res_taken_q, res_illegal_q, res_misalign_q;
    logic [WIDTH-1:0] res_link_q, target_q;
    logic [CNT_W-1:0] stat_br_q, stat_tk_q;

    logic             accept;
    logic [WIDTH-1:0] sum_pc_imm, sum_a_imm, target_c;
    logic             taken_c, illegal_c, misalign_c, is_branch_c;

    assign accept     = (state_q == StIdle) && bus.IDU_i_valid;
    assign sum_pc_imm = pc_q + imm_q;
    assign sum_a_imm  = val_a_q + imm_q;

    // Kind priority at accept: jalr > jal > branch
    always_comb begin
        kind_in = KindNone;
        if (bus.IDU_i_is_jalr)        kind_in = KindJalr;
        else if (bus.IDU_i_is_jal)    kind_in = KindJal;
        else if (bus.IDU_i_is_branch) kind_in = KindBranch;
    end

    // Taken condition, target and alignment from latched op and comparator flags
    always_comb begin
        taken_c     = 1'b0;
        illegal_c   = 1'b0;
        target_c    = sum_pc_imm;
        is_branch_c = 1'b0;
        unique case (kind_q)
            KindJalr: begin
                taken_c  = 1'b1;
                target_c = {sum_a_imm[WIDTH-1:1], 1'b0};
            end
            KindJal: taken_c = 1'b1;
            KindBranch: begin
                is_branch_c = 1'b1;
                case (funct3_q)
                    3'b000:         taken_c = bus.BR_JMP_i_br_eq;
                    3'b001:         taken_c = !bus.BR_JMP_i_br_eq;
                    3'b100, 3'b110: taken_c = bus.BR_JMP_i_br_lt;
                    3'b101, 3'b111: taken_c = !bus.BR_JMP_i_br_lt;
                    default:        illegal_c = 1'b1;
                endcase
            end
            KindNone: begin
                is_branch_c = 1'b1;
                illegal_c   = 1'b1;
            end
        endcase
    end

    assign misalign_c = taken_c & target_c[1];

    // Next-state logic and flush-window counter
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: if (bus.IDU_i_valid) state_d = StEval;
            StEval: state_d = (taken_c && !misalign_c) ? StRedirect : StIdle;
            StRedirect: begin
                if (bus.IFU_i_redirect_ready) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FcLast) state_d = StIdle;
                else                       flush_cnt_d = flush_cnt_q + 1'b1;
            end
        endcase
    end

    // State, operand latches, registered results and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            flush_cnt_q    <= '0;
            pc_q           <= '0;
            imm_q          <= '0;
            val_a_q        <= '0;
            val_b_q        <= '0;
            funct3_q       <= '0;
            kind_q         <= KindBranch;
            res_valid_q    <= 1'b0;
            res_taken_q    <= 1'b0;
            res_illegal_q  <= 1'b0;
            res_misalign_q <= 1'b0;
            res_link_q     <= '0;
            target_q       <= '0;
            stat_br_q      <= '0;
            stat_tk_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            res_valid_q <= (state_q == StEval);
            if (accept) begin
                pc_q     <= bus.IDU_i_pc;
                imm_q    <= bus.IDU_i_imm;
                val_a_q  <= bus.IDU_i_valA;
                val_b_q  <= bus.IDU_i_valB;
                funct3_q <= bus.IDU_i_funct3;
                kind_q   <= kind_in;
            end
            if (state_q == StEval) begin
                res_taken_q    <= taken_c;
                res_illegal_q  <= illegal_c;
                res_misalign_q <= misalign_c;
                res_link_q     <= pc_q + WIDTH'(4);
                target_q       <= target_c;
                if (is_branch_c) stat_br_q <= stat_br_q + 1'b1;
                if (taken_c)     stat_tk_q <= stat_tk_q + 1'b1;
            end
        end
    end

    assign bus.IDU_o_ready          = (state_q == StIdle);
    assign bus.CTRL_o_br_un         = funct3_q[1];
    assign bus.CTRL_o_valA          = val_a_q;
    assign bus.CTRL_o_valB          = val_b_q;
    assign bus.RES_o_valid          = res_valid_q;
    assign bus.RES_o_taken          = res_taken_q;
    assign bus.RES_o_link           = res_link_q;
    assign bus.RES_o_illegal        = res_illegal_q;
    assign bus.RES_o_misalign       = res_misalign_q;
    assign bus.IFU_o_redirect_valid = (state_q == StRedirect);
    assign bus.IFU_o_redirect_pc    = target_q;
    assign bus.PIPE_o_flush         = (state_q == StRedirect) || (state_q == StFlush);
    assign bus.STAT_o_branches      = stat_br_q;
    assign bus.STAT_o_taken         = stat_tk_q;
endmodule
